ram_bp_dp: RTL and testbench

- Parametrised simple-dual-port, byte-strobed, word-addressed block RAM with valid/ready handshakes on the write, read-request and read-response channels.
- Successor to the fixed 32-bit data memory. Adds:
  - depth and byte-lane generalisation
  - post-reset hardware zero-fill sequencer
  - backpressured read response
  - optional write-to-read forwarding
- Sits between the core's load/store unit and instruction/data fetch paths.

---
 rtl/ram_pkg.sv | 33 +++
 rtl/ram_bank.sv | 34 +++
 rtl/ram_bp_dp.sv | 136 +++++++++++++
 tb/tb_ram_bp_dp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-strobed dual-port RAM: FSM state
// encoding and the lane-merge function used by write-to-read forwarding.
package ram_pkg;

    typedef enum logic {
        RAM_INIT,
        RAM_RUN
    } ram_state_e;

    // Widest word/lane count lane_merge handles; callers zero-extend into it.
    localparam int MERGE_MAX_W     = 256;
    localparam int MERGE_MAX_LANES = 32;

    // Lane i of the result is new_word lane i where strb[i] is set, otherwise old_word lane i.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0]     old_word,
        input logic [MERGE_MAX_W-1:0]     new_word,
        input logic [MERGE_MAX_LANES-1:0] strb,
        input int                         byte_width
    );
        logic [MERGE_MAX_W-1:0] merged;
        int lane;
        merged = old_word;
        for (int b = 0; b < MERGE_MAX_W; b++) begin
            lane = b / byte_width;
            if (lane < MERGE_MAX_LANES && strb[lane[4:0]]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Pure storage array: one byte-strobed write port and one enabled,
// registered read port (read-first on address collision).
module ram_bank #(
    parameter int  ADDR_WIDTH = 11,
    parameter int  NUM_BYTES  = 4,
    parameter int  BYTE_WIDTH = 8,
    localparam int DATA_WIDTH = NUM_BYTES * BYTE_WIDTH,
    localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic [NUM_BYTES-1:0]  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset so the tools can
    // map them onto block RAM; the wrapper's zero-fill supplies known contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ram_bp_dp.sv
// Simple-dual-port byte-strobed RAM with zero-fill after reset, valid/ready
// write/read channels and a backpressured read response.
// Define RAM_BP_FWD_EN to forward same-cycle same-address write data into reads.
module ram_bp_dp
    import ram_pkg::*;
#(
    parameter int  ADDR_WIDTH = 11,
    parameter int  NUM_BYTES  = 4,
    parameter int  BYTE_WIDTH = 8,
    localparam int DATA_WIDTH = NUM_BYTES * BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    output logic                  o_init_done,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_BYTES-1:0]  i_wr_strb,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_valid,
    input  logic                  i_rd_resp_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    ram_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [NUM_BYTES-1:0]  bank_we;
    logic [ADDR_WIDTH-1:0] bank_waddr;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata;
    logic [DATA_WIDTH-1:0] resp_word;
    logic                  rd_fire;
    logic                  data_loaded_q;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        o_wr_ready = 1'b0;
        o_rd_ready = 1'b0;
        bank_we    = '0;
        bank_waddr = i_wr_addr;
        bank_wdata = i_wr_data;
        unique case (state_q)
            RAM_INIT: begin
                bank_we    = {NUM_BYTES{clk_en}};
                bank_waddr = fill_cnt_q;
                bank_wdata = '0;
                if (clk_en) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == '1) begin
                        state_d = RAM_RUN;
                    end
                end
            end
            RAM_RUN: begin
                o_wr_ready = 1'b1;
                o_rd_ready = !o_rd_valid || i_rd_resp_ready;
                bank_we    = i_wr_strb & {NUM_BYTES{clk_en & i_wr_valid}};
            end
        endcase
    end

    assign rd_fire = clk_en & i_rd_valid & o_rd_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RAM_INIT;
            fill_cnt_q    <= '0;
            o_init_done   <= 1'b0;
            o_rd_valid    <= 1'b0;
            data_loaded_q <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            o_init_done <= (state_q == RAM_RUN);
            if (rd_fire) begin
                o_rd_valid    <= 1'b1;
                data_loaded_q <= 1'b1;
            end else if (i_rd_resp_ready) begin
                o_rd_valid <= 1'b0;
            end
        end
    end

    // The read port advances only on acceptance, so a stalled response holds.
    ram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BYTES  (NUM_BYTES),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_bank (
        .clk     (clk),
        .wr_en   (bank_we),
        .wr_addr (bank_waddr),
        .wr_data (bank_wdata),
        .rd_en   (rd_fire),
        .rd_addr (i_rd_addr),
        .rd_data (bank_rdata)
    );

`ifdef RAM_BP_FWD_EN
    logic                  fwd_hit_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;
    logic [NUM_BYTES-1:0]  fwd_strb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_strb_q <= '0;
        end else if (rd_fire) begin
            fwd_hit_q  <= i_wr_valid && (i_wr_addr == i_rd_addr);
            fwd_data_q <= i_wr_data;
            fwd_strb_q <= i_wr_strb;
        end
    end

    assign resp_word = fwd_hit_q
        ? DATA_WIDTH'(lane_merge(MERGE_MAX_W'(bank_rdata), MERGE_MAX_W'(fwd_data_q),
                                 MERGE_MAX_LANES'(fwd_strb_q), BYTE_WIDTH))
        : bank_rdata;
`else
    assign resp_word = bank_rdata;
`endif

    // The bank's read register is unreset; report zero until the first read lands.
    assign o_rd_data = data_loaded_q ? resp_word : '0;

endmodule

// File: tb/tb_ram_bp_dp.sv
// Scoreboard bench for ram_bp_dp at ADDR_WIDTH=4: directed vectors push
// expected read data; a negedge monitor pops on each response transfer.
module tb_ram_bp_dp;
    import ram_pkg::*;

    localparam int AW = 4;
    localparam int NB = 4;
    localparam int BW = 8;
    localparam int DW = NB * BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          o_init_done;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [AW-1:0] i_wr_addr;
    logic [NB-1:0] i_wr_strb;
    logic [DW-1:0] i_wr_data;
    logic          i_rd_valid;
    logic          o_rd_ready;
    logic [AW-1:0] i_rd_addr;
    logic          o_rd_valid;
    logic          i_rd_resp_ready;
    logic [DW-1:0] o_rd_data;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];

    ram_bp_dp #(
        .ADDR_WIDTH (AW),
        .NUM_BYTES  (NB),
        .BYTE_WIDTH (BW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .o_init_done     (o_init_done),
        .i_wr_valid      (i_wr_valid),
        .o_wr_ready      (o_wr_ready),
        .i_wr_addr       (i_wr_addr),
        .i_wr_strb       (i_wr_strb),
        .i_wr_data       (i_wr_data),
        .i_rd_valid      (i_rd_valid),
        .o_rd_ready      (o_rd_ready),
        .i_rd_addr       (i_rd_addr),
        .o_rd_valid      (o_rd_valid),
        .i_rd_resp_ready (i_rd_resp_ready),
        .o_rd_data       (o_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        i_wr_strb  = s;
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        check("rd_ready_before_req", o_rd_ready, 1);
        exp_q.push_back(exp);
        i_rd_valid = 1'b1;
        i_rd_addr  = a;
        step();
        i_rd_valid = 1'b0;
    endtask

    // Counts enabled edges from reset release until o_init_done; optionally
    // drops clk_en for three edges once freeze_at enabled edges have passed.
    task automatic wait_init(input int freeze_at, output int n);
        int stalls;
        int guard;
        n = 0;
        stalls = 0;
        guard = 0;
        while (!o_init_done && guard < 200) begin
            clk_en = !(n == freeze_at && stalls < 3);
            @(posedge clk);
            #1;
            guard++;
            if (clk_en) begin
                n++;
                if (n == 16) begin
                    check("wr_ready_after_fill", o_wr_ready, 1);
                    check("init_done_not_yet", o_init_done, 0);
                end
            end else begin
                stalls++;
                check("init_frozen", o_init_done, 0);
            end
        end
        clk_en = 1'b1;
    endtask

    // Response monitor: a transfer happens at the next posedge when these hold.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && clk_en === 1'b1 && o_rd_valid === 1'b1 && i_rd_resp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_resp_unexpected: got 0x%0h expected no response", o_rd_data);
                end else begin
                    check("rd_resp", o_rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        clk_en = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_addr = '0;
        i_wr_strb = '0;
        i_wr_data = '0;
        i_rd_valid = 1'b0;
        i_rd_addr = '0;
        i_rd_resp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_init_done", o_init_done, 0);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_wr_ready", o_wr_ready, 0);
        check("rst_rd_ready", o_rd_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_init(-1, n);
        check("init_cycles", n, 17);

        // Zero-fill: every word reads zero, back to back
        for (int a = 0; a < 16; a++) rd(AW'(a), 32'h0);
        repeat (2) step();

        // Byte strobes
        wr(4'd3, 32'hDEADBEEF, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hDE22BE44);
        check("rd_latency_valid", o_rd_valid, 1);
        repeat (2) step();

        // Backpressure: response held, concurrent write does not disturb it
        i_rd_resp_ready = 1'b0;
        rd(4'd3, 32'hDE22BE44);
        i_wr_valid = 1'b1;
        i_wr_addr  = 4'd3;
        i_wr_data  = 32'h0;
        i_wr_strb  = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", o_rd_valid, 1);
            check("hold_data", o_rd_data, 32'hDE22BE44);
            check("hold_rd_ready", o_rd_ready, 0);
            step();
            i_wr_valid = 1'b0;
        end
        i_rd_resp_ready = 1'b1;
        step();
        rd(4'd3, 32'h0);
        repeat (2) step();

        // Same-cycle same-address write and read, then zero-strobe write
        wr(4'd5, 32'h12345678, 4'b1111);
        i_wr_valid = 1'b1;
        i_wr_addr  = 4'd5;
        i_wr_data  = 32'hAAAAAAAA;
        i_wr_strb  = 4'b0011;
`ifdef RAM_BP_FWD_EN
        rd(4'd5, 32'h1234AAAA);
`else
        rd(4'd5, 32'h12345678);
`endif
        i_wr_valid = 1'b0;
        wr(4'd5, 32'hFFFFFFFF, 4'b0000);
        rd(4'd5, 32'h1234AAAA);
        repeat (2) step();

        // clk_en low mid-response: nothing moves, nothing transfers
        i_rd_resp_ready = 1'b0;
        rd(4'd5, 32'h1234AAAA);
        clk_en = 1'b0;
        i_rd_resp_ready = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_addr  = 4'd5;
        i_wr_data  = 32'h0;
        i_wr_strb  = 4'b1111;
        i_rd_valid = 1'b1;
        i_rd_addr  = 4'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            check("freeze_valid", o_rd_valid, 1);
            check("freeze_data", o_rd_data, 32'h1234AAAA);
        end
        clk_en = 1'b1;
        i_wr_valid = 1'b0;
        i_rd_valid = 1'b0;
        step();
        rd(4'd5, 32'h1234AAAA);
        repeat (2) step();

        // Asynchronous reset with a pending response; fill with a clk_en gap
        wr(4'd7, 32'hCAFEF00D, 4'b1111);
        i_rd_resp_ready = 1'b0;
        i_rd_valid = 1'b1;
        i_rd_addr  = 4'd7;
        step();
        i_rd_valid = 1'b0;
        check("pre_rst_valid", o_rd_valid, 1);
        check("pre_rst_data", o_rd_data, 32'hCAFEF00D);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_valid", o_rd_valid, 0);
        check("async_rst_init_done", o_init_done, 0);
        check("async_rst_data", o_rd_data, 0);
        i_rd_resp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_init(5, n);
        check("reinit_cycles", n, 17);
        rd(4'd7, 32'h0);
        rd(4'd3, 32'h0);
        rd(4'd5, 32'h0);
        repeat (3) step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
